// File: rtl/decode_issue.sv
// Instruction queue plus decode/issue stage. Buffers fetched words and decodes the head.
// Each issued instruction goes to the RS or the LSB with its operands resolved from the regfile or the CDB.
module decode_issue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ROB_WIDTH   = 4,
    parameter int unsigned CDB_CNT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    inst_valid,
    input  logic [31:0]             inst,
    input  logic [31:0]             inst_pc,
    input  logic                    inst_pre_j,
    output logic                    queue_full,
    output logic [4:0]              reg_rs1,
    output logic [4:0]              reg_rs2,
    input  logic                    reg_rs1_rdy,
    input  logic [31:0]             reg_rs1_val,
    input  logic [ROB_WIDTH-1:0]    reg_rs1_rob_pos,
    input  logic                    reg_rs2_rdy,
    input  logic [31:0]             reg_rs2_val,
    input  logic [ROB_WIDTH-1:0]    reg_rs2_rob_pos,
    input  logic                    rob_full,
    input  logic [ROB_WIDTH-1:0]    rob_tail,
    input  logic                    rs_full,
    input  logic                    lsb_full,
    input  logic [CDB_CNT-1:0]      cdb_valid,
    input  logic [CDB_CNT*ROB_WIDTH-1:0] cdb_rob_pos,
    input  logic [CDB_CNT*32-1:0]   cdb_val,
    output logic                    done,
    output logic                    rs_en,
    output logic                    lsb_en,
    output logic [ROB_WIDTH-1:0]    rob_pos,
    output logic [6:0]              opcode,
    output logic [2:0]              funct3,
    output logic                    funct7,
    output logic [4:0]              rd,
    output logic [31:0]             imm,
    output logic [31:0]             pc,
    output logic                    pre_j,
    output logic                    rs1_rdy,
    output logic                    rs2_rdy,
    output logic [31:0]             rs1_val,
    output logic [31:0]             rs2_val,
    output logic [ROB_WIDTH-1:0]    rs1_rob_pos,
    output logic [ROB_WIDTH-1:0]    rs2_rob_pos
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_CALI  = 7'b0010011;
    localparam logic [6:0] OP_CAL   = 7'b0110011;

    logic [31:0]      inst_mem [QUEUE_DEPTH];
    logic [31:0]      pc_mem   [QUEUE_DEPTH];
    logic             prej_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] h_inst;
    logic [6:0]  h_op;
    logic        known, to_lsb, unit_full, enq, deq, issue, drop, rs1_use, rs2_use;
    logic [31:0] imm_c;
    logic        op1_rdy, op2_rdy;
    logic [31:0] op1_val, op2_val;
    logic [ROB_WIDTH-1:0] op1_pos, op2_pos;

    assign h_inst     = inst_mem[head_q];
    assign h_op       = h_inst[6:0];
    assign reg_rs1    = h_inst[19:15];
    assign reg_rs2    = h_inst[24:20];
    assign queue_full = (count_q == CNT_W'(QUEUE_DEPTH));

    // Class decode, handshakes and queue pointer update.
    always_comb begin
        known   = 1'b1;
        to_lsb  = 1'b0;
        rs1_use = 1'b1;
        rs2_use = 1'b0;
        case (h_op)
            OP_L:                    begin to_lsb = 1'b1; end
            OP_S:                    begin to_lsb = 1'b1; rs2_use = 1'b1; end
            OP_CAL, OP_B:            begin rs2_use = 1'b1; end
            OP_CALI, OP_JALR:        begin end
            OP_LUI, OP_AUIPC, OP_JAL: begin rs1_use = 1'b0; end
            default:                 begin known = 1'b0; rs1_use = 1'b0; end
        endcase
        unit_full = to_lsb ? lsb_full : rs_full;
        enq   = inst_valid & ~queue_full & rdy & ~rollback;
        issue = rdy & ~rollback & (count_q != '0) & known & ~rob_full & ~unit_full;
        drop  = rdy & ~rollback & (count_q != '0) & ~known;
        deq   = issue | drop;

        head_d  = deq ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (enq && !deq)      count_d = count_q + CNT_W'(1);
        else if (!enq && deq) count_d = count_q - CNT_W'(1);
        if (rollback) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Immediate formats by opcode.
    always_comb begin
        imm_c = 32'h0;
        case (h_op)
            OP_L, OP_CALI, OP_JALR: imm_c = {{20{h_inst[31]}}, h_inst[31:20]};
            OP_S:              imm_c = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
            OP_B:              imm_c = {{19{h_inst[31]}}, h_inst[31], h_inst[7],
                                        h_inst[30:25], h_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:  imm_c = {h_inst[31:12], 12'h0};
            OP_JAL:            imm_c = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12],
                                        h_inst[20], h_inst[30:21], 1'b0};
            default:           imm_c = 32'h0;
        endcase
    end

    // Operand resolution; scanning channels downward lets the lowest match win.
    always_comb begin
        op1_rdy = reg_rs1_rdy;
        op1_val = reg_rs1_rdy ? reg_rs1_val : 32'h0;
        op1_pos = reg_rs1_rdy ? '0 : reg_rs1_rob_pos;
        op2_rdy = reg_rs2_rdy;
        op2_val = reg_rs2_rdy ? reg_rs2_val : 32'h0;
        op2_pos = reg_rs2_rdy ? '0 : reg_rs2_rob_pos;
        for (int c = int'(CDB_CNT) - 1; c >= 0; c--) begin
            if (!reg_rs1_rdy && cdb_valid[c] &&
                cdb_rob_pos[c*ROB_WIDTH +: ROB_WIDTH] == reg_rs1_rob_pos) begin
                op1_rdy = 1'b1;
                op1_val = cdb_val[c*32 +: 32];
            end
            if (!reg_rs2_rdy && cdb_valid[c] &&
                cdb_rob_pos[c*ROB_WIDTH +: ROB_WIDTH] == reg_rs2_rob_pos) begin
                op2_rdy = 1'b1;
                op2_val = cdb_val[c*32 +: 32];
            end
        end
        if (!rs1_use) begin
            op1_rdy = 1'b1;
            op1_val = 32'h0;
            op1_pos = '0;
        end
        if (!rs2_use) begin
            op2_rdy = 1'b1;
            op2_val = 32'h0;
            op2_pos = '0;
        end
    end

    // Queue storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            inst_mem[tail_q] <= inst;
            pc_mem[tail_q]   <= inst_pc;
            prej_mem[tail_q] <= inst_pre_j;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;      tail_q <= '0;      count_q <= '0;
            done <= 1'b0;      rs_en <= 1'b0;     lsb_en <= 1'b0;
            rob_pos <= '0;     opcode <= '0;      funct3 <= '0;
            funct7 <= 1'b0;    rd <= '0;          imm <= '0;
            pc <= '0;          pre_j <= 1'b0;
            rs1_rdy <= 1'b1;   rs2_rdy <= 1'b1;
            rs1_val <= '0;     rs2_val <= '0;
            rs1_rob_pos <= '0; rs2_rob_pos <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done    <= issue;
            rs_en   <= issue & ~to_lsb;
            lsb_en  <= issue & to_lsb;
            if (issue) begin
                rob_pos     <= rob_tail;
                opcode      <= h_op;
                funct3      <= h_inst[14:12];
                funct7      <= h_inst[30];
                rd          <= (h_op == OP_S || h_op == OP_B) ? 5'd0 : h_inst[11:7];
                imm         <= imm_c;
                pc          <= pc_mem[head_q];
                pre_j       <= prej_mem[head_q];
                rs1_rdy     <= op1_rdy;
                rs2_rdy     <= op2_rdy;
                rs1_val     <= op1_val;
                rs2_val     <= op2_val;
                rs1_rob_pos <= op1_pos;
                rs2_rob_pos <= op2_pos;
            end
        end
    end
endmodule
